// File: rtl/writeback_if.sv
// Shared widths plus the bundle of signals between exec/decode/trap logic and
// the integer writeback stage.
package writeback_pkg;
  localparam int XLEN = 32;
  localparam int ALEN = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } wb_state_e;
endpackage

interface writeback_if #(
  parameter int INSTRET_W = 64
);
  // Issue side (decode)
  logic                           issue_valid;
  logic [4:0]                     issue_rd;
  logic [writeback_pkg::ALEN-1:0] issue_addr;
  // Exec result side
  logic                           exec_int_output_valid;
  logic                           exec_int_exception;
  logic [writeback_pkg::XLEN-1:0] exec_int_result;
  // Trap handshake
  logic                           trap_ack;
  logic                           trap_valid;
  logic [writeback_pkg::ALEN-1:0] trap_addr;
  // Register file write port
  logic                           reg_write_en;
  logic [4:0]                     reg_write_sel;
  logic [writeback_pkg::XLEN-1:0] reg_write_data;
  // Status back to decode
  logic                           wb_stall;
  logic                           pending_rd_valid;
  logic [4:0]                     pending_rd;
  logic [INSTRET_W-1:0]           instret;
  logic                           protocol_error;

  modport master (
    output issue_valid, issue_rd, issue_addr,
    output exec_int_output_valid, exec_int_exception, exec_int_result,
    output trap_ack,
    input  trap_valid, trap_addr,
    input  reg_write_en, reg_write_sel, reg_write_data,
    input  wb_stall, pending_rd_valid, pending_rd, instret, protocol_error
  );

  modport slave (
    input  issue_valid, issue_rd, issue_addr,
    input  exec_int_output_valid, exec_int_exception, exec_int_result,
    input  trap_ack,
    output trap_valid, trap_addr,
    output reg_write_en, reg_write_sel, reg_write_data,
    output wb_stall, pending_rd_valid, pending_rd, instret, protocol_error
  );
endinterface

// File: rtl/writeback.sv
// Integer writeback stage: pairs each exec result with the op issued one cycle
// earlier, retires it to the register file, or raises a held trap request.
module writeback
  import writeback_pkg::*;
#(
  parameter int INSTRET_W = 64
) (
  input logic         clk,
  input logic         rst,
  writeback_if.slave  wb
);

  wb_state_e            state_q, state_d;
  logic                 al_valid_q, al_valid_d;
  logic [4:0]           al_rd_q, al_rd_d;
  logic [ALEN-1:0]      al_addr_q, al_addr_d;
  logic                 reg_write_en_q, reg_write_en_d;
  logic [4:0]           reg_write_sel_q, reg_write_sel_d;
  logic [XLEN-1:0]      reg_write_data_q, reg_write_data_d;
  logic                 trap_valid_q, trap_valid_d;
  logic [ALEN-1:0]      trap_addr_q, trap_addr_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 protocol_error_q, protocol_error_d;
  logic                 wb_stall;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d          = state_q;
    al_valid_d       = wb.issue_valid;
    al_rd_d          = wb.issue_rd;
    al_addr_d        = wb.issue_addr;
    reg_write_en_d   = 1'b0;
    reg_write_sel_d  = reg_write_sel_q;
    reg_write_data_d = reg_write_data_q;
    trap_valid_d     = trap_valid_q;
    trap_addr_d      = trap_addr_q;
    instret_d        = instret_q;
    protocol_error_d = protocol_error_q;
    wb_stall         = 1'b0;

    case (state_q)
      ST_RUN: begin
        // Stall decode in the same cycle a fault appears so nothing issues behind it.
        wb_stall = wb.exec_int_output_valid && wb.exec_int_exception;
        if (wb.exec_int_output_valid != al_valid_q) begin
          protocol_error_d = 1'b1;
        end
        if (wb.exec_int_output_valid && al_valid_q) begin
          if (wb.exec_int_exception) begin
            trap_valid_d = 1'b1;
            trap_addr_d  = al_addr_q;
            state_d      = ST_TRAP;
          end else begin
            reg_write_en_d   = (al_rd_q != 5'd0);
            reg_write_sel_d  = al_rd_q;
            reg_write_data_d = wb.exec_int_result;
            instret_d        = instret_q + INSTRET_W'(1);
          end
        end
      end
      ST_TRAP: begin
        // Results arriving while the trap is pending are dropped silently.
        wb_stall = 1'b1;
        if (wb.trap_ack) begin
          trap_valid_d = 1'b0;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_RUN;
      al_valid_q       <= 1'b0;
      al_rd_q          <= '0;
      al_addr_q        <= '0;
      reg_write_en_q   <= 1'b0;
      reg_write_sel_q  <= '0;
      reg_write_data_q <= '0;
      trap_valid_q     <= 1'b0;
      trap_addr_q      <= '0;
      instret_q        <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      al_valid_q       <= al_valid_d;
      al_rd_q          <= al_rd_d;
      al_addr_q        <= al_addr_d;
      reg_write_en_q   <= reg_write_en_d;
      reg_write_sel_q  <= reg_write_sel_d;
      reg_write_data_q <= reg_write_data_d;
      trap_valid_q     <= trap_valid_d;
      trap_addr_q      <= trap_addr_d;
      instret_q        <= instret_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign wb.reg_write_en     = reg_write_en_q;
  assign wb.reg_write_sel    = reg_write_sel_q;
  assign wb.reg_write_data   = reg_write_data_q;
  assign wb.trap_valid       = trap_valid_q;
  assign wb.trap_addr        = trap_addr_q;
  assign wb.wb_stall         = wb_stall;
  assign wb.pending_rd_valid = al_valid_q && (al_rd_q != 5'd0);
  assign wb.pending_rd       = al_rd_q;
  assign wb.instret          = instret_q;
  assign wb.protocol_error   = protocol_error_q;

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: expected register writes go into a queue and
// a negedge monitor pops and compares each write pulse the DUT produces.
module tb_writeback;
  import writeback_pkg::*;

  localparam int IW = 4;  // narrow counter so the wrap is reachable quickly

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  writeback_if #(.INSTRET_W(IW)) bus ();
  writeback #(.INSTRET_W(IW)) dut (.clk(clk), .rst(rst), .wb(bus));

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  exp_ir = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.issue_valid           = 1'b0;
    bus.issue_rd              = '0;
    bus.issue_addr            = '0;
    bus.exec_int_output_valid = 1'b0;
    bus.exec_int_exception    = 1'b0;
    bus.exec_int_result       = '0;
    bus.trap_ack              = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ir();
    check("instret", 64'(bus.instret), 64'(exp_ir));
  endtask

  // Back-to-back ops: each cycle issues op i while exec returns op i-1.
  task automatic burst(input int n, input int rd_base, input int data_base);
    for (int i = 0; i <= n; i++) begin
      idle();
      bus.issue_valid = (i < n);
      bus.issue_rd    = 5'(rd_base + i);
      bus.issue_addr  = ALEN'(32'h40 + 4 * i);
      if (i > 0) begin
        bus.exec_int_output_valid = 1'b1;
        bus.exec_int_result       = XLEN'(data_base + i - 1);
        if (5'(rd_base + i - 1) != 5'd0)
          exp_q.push_back('{rd: 5'(rd_base + i - 1), data: XLEN'(data_base + i - 1)});
      end
      tick();
    end
    idle();
    exp_ir = (exp_ir + n) % (1 << IW);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.reg_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: sel=%0d data=0x%0h, expected no write (t=%0t)",
                 bus.reg_write_sel, bus.reg_write_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_sel", 64'(bus.reg_write_sel), 64'(e.rd));
        check("wr_data", 64'(bus.reg_write_data), 64'(e.data));
      end
    end
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", 64'(bus.reg_write_en), 64'd0);
    check("rst_wr_sel", 64'(bus.reg_write_sel), 64'd0);
    check("rst_wr_data", 64'(bus.reg_write_data), 64'd0);
    check("rst_trap_valid", 64'(bus.trap_valid), 64'd0);
    check("rst_trap_addr", 64'(bus.trap_addr), 64'd0);
    check("rst_stall", 64'(bus.wb_stall), 64'd0);
    check("rst_perr", 64'(bus.protocol_error), 64'd0);
    check("rst_pending", 64'(bus.pending_rd_valid), 64'd0);
    check_ir();
    rst = 1'b1;
    tick();

    // Single retire rd=5, data 0x1234: write lands two edges after issue.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.issue_addr = 'h10;
    tick();
    check("pending_valid", 64'(bus.pending_rd_valid), 64'd1);
    check("pending_rd", 64'(bus.pending_rd), 64'd5);
    check("no_early_write", 64'(bus.reg_write_en), 64'd0);
    idle();
    bus.exec_int_output_valid = 1'b1; bus.exec_int_result = 'h1234;
    exp_q.push_back('{rd: 5'd5, data: XLEN'(32'h1234)});
    tick();
    exp_ir = 1;
    check("wr_pulse", 64'(bus.reg_write_en), 64'd1);
    check_ir();
    idle();
    tick();
    check("wr_pulse_single", 64'(bus.reg_write_en), 64'd0);

    // rd=0 retires without a write strobe.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.issue_addr = 'h14;
    tick();
    check("pending_rd0", 64'(bus.pending_rd_valid), 64'd0);
    idle();
    bus.exec_int_output_valid = 1'b1; bus.exec_int_result = 'hFFFF;
    tick();
    exp_ir = 2;
    check("rd0_no_write", 64'(bus.reg_write_en), 64'd0);
    check_ir();
    idle();
    tick();

    // Four back-to-back ops rd 1..4.
    burst(4, 1, 'hA0);
    check_ir();
    tick();

    // Exception at address 0x100.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.issue_addr = 'h100;
    tick();
    idle();
    bus.exec_int_output_valid = 1'b1; bus.exec_int_exception = 1'b1; bus.exec_int_result = 'hBAD;
    #1;
    check("stall_comb", 64'(bus.wb_stall), 64'd1);
    check("trap_not_yet", 64'(bus.trap_valid), 64'd0);
    tick();
    check("trap_valid", 64'(bus.trap_valid), 64'd1);
    check("trap_addr", 64'(bus.trap_addr), 64'h100);
    check("trap_stall", 64'(bus.wb_stall), 64'd1);
    check("trap_no_write", 64'(bus.reg_write_en), 64'd0);
    check_ir();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.issue_addr = 'h180;
    tick();
    idle();
    bus.exec_int_output_valid = 1'b1; bus.exec_int_result = 'hDEAD;
    tick();
    check("trap_discard_wr", 64'(bus.reg_write_en), 64'd0);
    check_ir();
    idle();
    bus.exec_int_output_valid = 1'b1; bus.exec_int_exception = 1'b1;
    tick();
    check("trap_addr_stable", 64'(bus.trap_addr), 64'h100);
    check("trap_no_perr", 64'(bus.protocol_error), 64'd0);
    idle();
    tick();
    check("trap_held", 64'(bus.trap_valid), 64'd1);
    bus.trap_ack = 1'b1;
    tick();
    check("ack_trap_valid", 64'(bus.trap_valid), 64'd0);
    check("ack_stall", 64'(bus.wb_stall), 64'd0);
    tick();
    check("ack_in_run_ignored", 64'(bus.trap_valid), 64'd0);
    idle();

    // Counter wrap: reach all-ones minus one, then two more retires give 0.
    burst(8, 10, 'h500);
    check_ir();
    tick();
    burst(2, 0, 'h600);
    check_ir();
    check("perr_clean", 64'(bus.protocol_error), 64'd0);
    tick();

    // Exec result with no aligned issue.
    bus.exec_int_output_valid = 1'b1; bus.exec_int_result = 'h777;
    tick();
    check("perr_set", 64'(bus.protocol_error), 64'd1);
    check("perr_no_write", 64'(bus.reg_write_en), 64'd0);
    check_ir();
    idle();
    repeat (3) tick();
    check("perr_sticky", 64'(bus.protocol_error), 64'd1);

    // Reset while a trap is pending and another op is in flight.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd8; bus.issue_addr = 'h200;
    tick();
    idle();
    bus.exec_int_output_valid = 1'b1; bus.exec_int_exception = 1'b1;
    tick();
    check("trap2_valid", 64'(bus.trap_valid), 64'd1);
    check("trap2_addr", 64'(bus.trap_addr), 64'h200);
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
    tick();
    idle();
    bus.exec_int_output_valid = 1'b1; bus.exec_int_result = 'h999;
    #2;
    rst = 1'b0;
    #1;
    check("arst_trap_valid", 64'(bus.trap_valid), 64'd0);
    check("arst_trap_addr", 64'(bus.trap_addr), 64'd0);
    check("arst_stall", 64'(bus.wb_stall), 64'd0);
    check("arst_pending", 64'(bus.pending_rd_valid), 64'd0);
    check("arst_perr", 64'(bus.protocol_error), 64'd0);
    exp_ir = 0;
    check_ir();
    idle();
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("post_rst_no_write", 64'(bus.reg_write_en), 64'd0);
    check("post_rst_trap", 64'(bus.trap_valid), 64'd0);
    check("post_rst_perr", 64'(bus.protocol_error), 64'd0);
    check_ir();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter INSTRET_W, default 64, width of the retired-instruction counter. XLEN and ALEN come from the shared params header.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 issue_valid  input  1  an integer op enters exec this cycle (input_valid && input_is_int).
REQ-005 issue_rd  input  5  destination register of the issuing op.
REQ-006 issue_addr  input  ALEN  instruction address of the issuing op.
REQ-007 exec_int_output_valid  input  1  exec result valid; arrives one cycle after issue.
REQ-008 exec_int_exception  input  1  the exec result raised an illegal-instruction exception.
REQ-009 exec_int_result  input  XLEN  exec result data.
REQ-010 trap_ack  input  1  trap handler has accepted the pending trap.
REQ-011 reg_write_en  output  1  register-file write strobe.
REQ-012 reg_write_sel  output  5  register-file write index.
REQ-013 reg_write_data  output  XLEN  register-file write data.
REQ-014 trap_valid  output  1  a trap request is pending.
REQ-015 trap_addr  output  ALEN  address of the faulting instruction.
REQ-016 wb_stall  output  1  decode must not issue.
REQ-017 pending_rd_valid, pending_rd  output  1, 5  an in-flight op will write pending_rd; used by decode for hazard checks.
REQ-018 instret  output  INSTRET_W  count of retired instructions.
REQ-019 protocol_error  output  1  sticky flag; an exec result arrived without an aligned issue, or vice versa.

Function
REQ-020 Alignment register: each cycle, issue_valid, issue_rd and issue_addr are captured into a one-entry stage (al_valid, al_rd, al_addr) that pairs with the exec output of the next cycle.
REQ-021 pending_rd_valid equals al_valid && al_rd != 0, and pending_rd equals al_rd.
REQ-022 State machine, states RUN and TRAP; reset state is RUN.
REQ-023 Normal retire (RUN, exec_int_output_valid=1, exception=0, al_valid=1): on the next edge, reg_write_en = (al_rd != 0), reg_write_sel = al_rd, reg_write_data = exec_int_result, and instret increments by 1. Total latency from issue to write is 2 cycles.
REQ-024 rd=0: no write is strobed, but instret still increments.
REQ-025 reg_write_en is a single-cycle pulse per retire and is low in every cycle without a retire.
REQ-026 Exception (RUN, valid=1, exception=1, al_valid=1): no register write and no instret increment; on the next edge trap_valid=1, trap_addr=al_addr, and the state becomes TRAP.
REQ-027 In TRAP: wb_stall=1 and trap_valid is held with trap_addr stable. All exec results are discarded, with no write, no instret increment and no new trap.
REQ-028 trap_ack while in TRAP: on the next edge trap_valid=0 and the state returns to RUN; wb_stall drops in that same edge.
REQ-029 trap_ack while in RUN is ignored.
REQ-030 wb_stall is asserted combinationally when exec_int_output_valid && exec_int_exception in RUN, so no op issues behind a faulting op.
REQ-031 Mismatch: exec_int_output_valid != al_valid in RUN sets protocol_error=1 until reset. A mismatched result is discarded.
REQ-032 instret wraps modulo 2^INSTRET_W with no flag.
REQ-033 Ordering: exec precedes issue, so an issue in the same cycle as an exec-valid is captured normally.

Reset
REQ-034 Asynchronous assertion (rst=0) immediately clears the alignment stage, reg_write_en, trap_valid, wb_stall, protocol_error and instret to 0, and sets the state to RUN.
REQ-035 reg_write_sel, reg_write_data and trap_addr reset to 0.
REQ-036 Reset in mid-operation (in-flight op or pending trap) discards that op or trap. Nothing is written after deassertion.
REQ-037 Reset deassertion takes effect on the first rising clk edge after rst goes high.

Verification
REQ-038 Issue rd=5 at cycle 0, exec result 0x1234 at cycle 1 -> at cycle 2 reg_write_en=1, sel=5, data=0x1234, instret=1.
REQ-039 Issue rd=0 with result 0xFFFF -> reg_write_en stays 0 and instret increments by 1.
REQ-040 Issue addr=0x100, exec exception at cycle 1 -> wb_stall=1 in cycle 1; trap_valid=1, trap_addr=0x100 from cycle 2. A further exec-valid during TRAP causes no write. trap_ack at cycle 5 -> trap_valid=0 and wb_stall=0 at cycle 6.
REQ-041 exec_int_output_valid=1 with no prior issue -> protocol_error=1 and stays 1; no write.
REQ-042 Back-to-back issues at cycles 0-3 with rd 1..4 -> four consecutive write pulses at cycles 2-5 and instret=4.
REQ-043 Preload instret to all-ones minus 1 and retire 2 ops -> instret=0. Pull rst low mid-trap -> trap_valid=0 immediately.
